// File: rtl/otter_ctrl_pkg.sv
// Shared types and helpers for the OTTER pipeline hazard controller.
package otter_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    FREEZE = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic pc_we;
    logic if_de_we;
    logic de_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_de_flush;
    logic de_ex_flush;
  } pipe_ctl_t;

  function automatic logic reg_hit(input logic [4:0] rs, input logic rs_used,
                                   input logic [4:0] rd, input logic rd_used,
                                   input logic reg_write);
    return rs_used && rd_used && reg_write && (rs == rd);
  endfunction

  function automatic pipe_ctl_t ctl_for(input ctrl_state_t act);
    pipe_ctl_t c;
    c = '{pc_we: 1'b1, if_de_we: 1'b1, de_ex_we: 1'b1, ex_mem_we: 1'b1,
          mem_wb_we: 1'b1, if_de_flush: 1'b0, de_ex_flush: 1'b0};
    case (act)
      STALL: begin
        c.pc_we       = 1'b0;
        c.if_de_we    = 1'b0;
        c.de_ex_flush = 1'b1;
      end
      FLUSH: begin
        c.if_de_flush = 1'b1;
        c.de_ex_flush = 1'b1;
      end
      FREEZE: begin
        c = '0;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/otter_fwd_unit.sv
// Per-operand hazard match: EX-stage forward select, load-use detect and
// DE-stage write-back bypass. Purely combinational.
module otter_fwd_unit
  import otter_ctrl_pkg::*;
(
  input  logic [4:0] rs_addr_i,
  input  logic       rs_used_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_rd_used_i,
  input  logic       ex_reg_write_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] mem_rd_addr_i,
  input  logic       mem_rd_used_i,
  input  logic       mem_reg_write_i,
  input  logic [4:0] wb_rd_addr_i,
  input  logic       wb_reg_write_i,
  output fwd_sel_t   fwd_sel_o,
  output logic       load_use_o,
  output logic       de_byp_o
);

  logic ex_hit;
  logic mem_hit;

  always_comb begin
    ex_hit     = reg_hit(rs_addr_i, rs_used_i, ex_rd_addr_i, ex_rd_used_i, ex_reg_write_i);
    mem_hit    = reg_hit(rs_addr_i, rs_used_i, mem_rd_addr_i, mem_rd_used_i, mem_reg_write_i);
    load_use_o = ex_hit && ex_mem_read_i;
    // Youngest producer wins; a load in EX cannot forward yet, the stall covers it.
    fwd_sel_o  = FWD_NONE;
    if (ex_hit && !ex_mem_read_i) begin
      fwd_sel_o = FWD_EXMEM;
    end else if (mem_hit) begin
      fwd_sel_o = FWD_MEMWB;
    end
    de_byp_o = rs_used_i && wb_reg_write_i && (wb_rd_addr_i == rs_addr_i) &&
               (wb_rd_addr_i != 5'd0);
  end

endmodule

// File: rtl/otter_hazard_ctrl.sv
// OTTER 5-stage hazard controller: priority busy > redirect > load-use > run,
// pipeline enables/flushes, registered forward selects and saturating perf counters.
module otter_hazard_ctrl
  import otter_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       DE_RS1_ADDR,
  input  logic [4:0]       DE_RS2_ADDR,
  input  logic             DE_RS1_USED,
  input  logic             DE_RS2_USED,
  input  logic [4:0]       EX_RD_ADDR,
  input  logic             EX_RD_USED,
  input  logic             EX_REG_WRITE,
  input  logic             EX_MEM_READ,
  input  logic [4:0]       MEM_RD_ADDR,
  input  logic             MEM_RD_USED,
  input  logic             MEM_REG_WRITE,
  input  logic [4:0]       WB_RD_ADDR,
  input  logic             WB_REG_WRITE,
  input  logic             EX_REDIRECT,
  input  logic             MEM_BUSY,
  output logic             PC_WRITE,
  output logic             IF_DE_WRITE,
  output logic             DE_EX_WRITE,
  output logic             EX_MEM_WRITE,
  output logic             MEM_WB_WRITE,
  output logic             IF_DE_FLUSH,
  output logic             DE_EX_FLUSH,
  output logic [1:0]       FWD_A_SEL,
  output logic [1:0]       FWD_B_SEL,
  output logic             DE_BYP_A,
  output logic             DE_BYP_B,
  output logic [1:0]       CTRL_STATE,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  ctrl_state_t      state_q, state_d;
  fwd_sel_t         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  fwd_sel_t         fwd_a_calc, fwd_b_calc;
  logic             load_use_a, load_use_b;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  pipe_ctl_t        ctl;

  otter_fwd_unit u_fwd_a (
    .rs_addr_i      (DE_RS1_ADDR),
    .rs_used_i      (DE_RS1_USED),
    .ex_rd_addr_i   (EX_RD_ADDR),
    .ex_rd_used_i   (EX_RD_USED),
    .ex_reg_write_i (EX_REG_WRITE),
    .ex_mem_read_i  (EX_MEM_READ),
    .mem_rd_addr_i  (MEM_RD_ADDR),
    .mem_rd_used_i  (MEM_RD_USED),
    .mem_reg_write_i(MEM_REG_WRITE),
    .wb_rd_addr_i   (WB_RD_ADDR),
    .wb_reg_write_i (WB_REG_WRITE),
    .fwd_sel_o      (fwd_a_calc),
    .load_use_o     (load_use_a),
    .de_byp_o       (DE_BYP_A)
  );

  otter_fwd_unit u_fwd_b (
    .rs_addr_i      (DE_RS2_ADDR),
    .rs_used_i      (DE_RS2_USED),
    .ex_rd_addr_i   (EX_RD_ADDR),
    .ex_rd_used_i   (EX_RD_USED),
    .ex_reg_write_i (EX_REG_WRITE),
    .ex_mem_read_i  (EX_MEM_READ),
    .mem_rd_addr_i  (MEM_RD_ADDR),
    .mem_rd_used_i  (MEM_RD_USED),
    .mem_reg_write_i(MEM_REG_WRITE),
    .wb_rd_addr_i   (WB_RD_ADDR),
    .wb_reg_write_i (WB_REG_WRITE),
    .fwd_sel_o      (fwd_b_calc),
    .load_use_o     (load_use_b),
    .de_byp_o       (DE_BYP_B)
  );

  // state_d is the action applied at the coming edge; state_q reports the last one.
  always_comb begin
    state_d     = RUN;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (RST) begin
      state_d = RUN;
    end else if (MEM_BUSY) begin
      state_d = FREEZE;
    end else if (EX_REDIRECT) begin
      state_d = FLUSH;
    end else if (load_use_a || load_use_b) begin
      state_d = STALL;
    end

    case (state_d)
      RUN: begin
        fwd_a_d = fwd_a_calc;
        fwd_b_d = fwd_b_calc;
      end
      STALL, FLUSH: begin
        fwd_a_d = FWD_NONE;
        fwd_b_d = FWD_NONE;
      end
      default: ;
    endcase

    if ((state_d == STALL || state_d == FREEZE) && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (state_d == FLUSH && flush_cnt_q != '1) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      fwd_a_q     <= FWD_NONE;
      fwd_b_q     <= FWD_NONE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ctl          = ctl_for(state_d);
  assign PC_WRITE     = ctl.pc_we;
  assign IF_DE_WRITE  = ctl.if_de_we;
  assign DE_EX_WRITE  = ctl.de_ex_we;
  assign EX_MEM_WRITE = ctl.ex_mem_we;
  assign MEM_WB_WRITE = ctl.mem_wb_we;
  assign IF_DE_FLUSH  = ctl.if_de_flush;
  assign DE_EX_FLUSH  = ctl.de_ex_flush;
  assign FWD_A_SEL    = fwd_a_q;
  assign FWD_B_SEL    = fwd_b_q;
  assign CTRL_STATE   = state_q;
  assign STALL_CNT    = stall_cnt_q;
  assign FLUSH_CNT    = flush_cnt_q;

endmodule

// File: doc/otter_hazard_ctrl.md
# otter_hazard_ctrl

Pipeline hazard controller for the 5-stage OTTER RV32I core. It detects load-use hazards, taken-branch and jump redirects, and memory-port wait requests. From these it drives the write-enable and flush controls of the PC and of the IF/DE, DE/EX and EX/MEM pipeline registers. It also produces registered operand-forwarding selects for the EX stage, DE-stage write-back bypass selects, and stall/flush performance counters.

## Interface
- CNT_W, 32, width of performance counters
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- DE_RS1_ADDR, DE_RS2_ADDR  in  5 each  source registers of instruction in DE
- DE_RS1_USED, DE_RS2_USED  in  1 each  source actually read (already 0 for x0)
- EX_RD_ADDR  in  5  destination of instruction in EX
- EX_RD_USED, EX_REG_WRITE, EX_MEM_READ  in  1 each  EX destination valid / writes RF / is LOAD
- MEM_RD_ADDR  in  5  destination of instruction in MEM
- MEM_RD_USED, MEM_REG_WRITE  in  1 each
- WB_RD_ADDR  in  5  destination of instruction in WB
- WB_REG_WRITE  in  1
- EX_REDIRECT  in  1  EX resolved taken branch, JAL or JALR
- MEM_BUSY  in  1  memory port requests multi-cycle wait
- PC_WRITE, IF_DE_WRITE, DE_EX_WRITE, EX_MEM_WRITE, MEM_WB_WRITE  out  1 each  register load enables
- IF_DE_FLUSH, DE_EX_FLUSH  out  1 each  synchronous clear of the register (all-zero = bubble)
- FWD_A_SEL, FWD_B_SEL  out  2 each  registered EX operand select: 00 pipeline value, 01 EX/MEM ALU result, 10 MEM/WB write-back data
- DE_BYP_A, DE_BYP_B  out  1 each  DE read must take WB write data instead of RF output
- CTRL_STATE  out  2  action applied at last edge: RUN, STALL, FLUSH, FREEZE
- STALL_CNT, FLUSH_CNT  out  CNT_W each  performance counters

## Operation
- Match on rs: `hit(rs, rd) = rs_used && rd_used && reg_write && rs == rd`.
- Priority is MEM_BUSY > EX_REDIRECT > load-use > normal. Exactly one action is applied per cycle.
- FREEZE (MEM_BUSY=1):
  - All *_WRITE outputs are 0 and both flushes are 0.
  - FWD_*_SEL and the counters hold; STALL_CNT still increments.
  - A concurrent redirect or load-use is not lost; EX is held, so the condition re-evaluates after release.
- FLUSH (EX_REDIRECT=1, no busy):
  - All enables are 1, with IF_DE_FLUSH=1 and DE_EX_FLUSH=1, giving two bubbles.
  - FWD_*_SEL loads 00. FLUSH_CNT increments.
- STALL (load-use: EX_MEM_READ and hit(DE_RSx, EX_RD)):
  - PC_WRITE=0 and IF_DE_WRITE=0.
  - DE_EX_FLUSH=1, which injects a bubble; EX_MEM_WRITE and MEM_WB_WRITE are 1.
  - FWD_*_SEL loads 00. STALL_CNT increments.
  - On the next cycle the load is in MEM, and DE re-evaluates to forward 10.
- RUN: all enables are 1, with no flush.
- Forward select computation, loaded into FWD_x_SEL when DE_EX_WRITE=1 and not flushed:
  - 01 if hit(DE_RSx, EX_RD) with EX not a load.
  - Otherwise 10 if hit(DE_RSx, MEM_RD).
  - Otherwise 00.
  - The youngest producer wins.
- DE_BYP_x = DE_RSx_USED && WB_REG_WRITE && WB_RD_ADDR == DE_RSx_ADDR && WB_RD_ADDR != 0. This output is combinational.
- Counters saturate at all-ones and do not wrap.

## Timing
- Enable, flush and DE_BYP outputs are combinational from the current-cycle inputs and take effect at the next CLK edge.
- FWD_*_SEL and CTRL_STATE are registered, valid in the cycle after the edge that moves the instruction into EX.
- Load-use costs exactly 1 cycle. Redirect costs 2 bubbles. Freeze costs N cycles for N busy cycles.
- Reset: while RST=1, all *_WRITE=1, flushes=0, FWD_*_SEL=00, CTRL_STATE=RUN, counters=0, DE_BYP per formula. Pipeline registers clear under their own RST.
- RST asserted mid-stall or mid-freeze returns to RUN on the next edge. Counters restart from 0.
- Simultaneous redirect and load-use: FLUSH wins, because the DE instruction is wrong-path. STALL_CNT is unchanged.

## Structure
- Package otter_ctrl_pkg holds:
  - fwd_sel_t enum: FWD_NONE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - ctrl_state_t enum: RUN=0, STALL=1, FLUSH=2, FREEZE=3.
- Sub-module otter_fwd_unit is the combinational per-operand match and select. It is instantiated twice, for A and B.
- The top holds the priority logic, the FWD/state registers and the counters.

## Test plan
- ADDI x5 then ADD x6,x5,x5 back-to-back:
  - FWD_A_SEL=FWD_B_SEL=01 in the ADD's EX cycle, with no stall.
- LW x7 then ADD x8,x7,x1:
  - PC_WRITE=0, IF_DE_WRITE=0 and DE_EX_FLUSH=1 for one cycle; STALL_CNT=1.
  - Then FWD_A_SEL=10 and FWD_B_SEL=00.
- EX_REDIRECT=1 for one cycle:
  - IF_DE_FLUSH=DE_EX_FLUSH=1; FLUSH_CNT=1; CTRL_STATE=FLUSH the next cycle.
- MEM_BUSY held 3 cycles while a load-use hazard is present:
  - All enables are 0 for 3 cycles, STALL_CNT +3 and FWD held.
  - Then a 1-cycle load-use stall; STALL_CNT=4.
- Redirect coincident with load-use:
  - Flushes only, no PC hold; STALL_CNT=0 and FLUSH_CNT=1.
- x0 destination (ADDI x0) followed by a read of x0:
  - FWD_*_SEL=00 and DE_BYP=0.
- RST asserted during freeze:
  - Outputs return to reset values the next edge; counters=0.
